pkt_sampler: RTL and testbench
==============================

# pkt_sampler

Packet-stream sampling stage that sits directly upstream of the wrap-around counter atom and absorbs that counter's function internally. Each accepted packet advances a modulo-PERIOD phase counter. The packet that arrives at phase 0 is tagged as a sample. Accepted packets leave through a one-entry registered output with a valid/ready handshake, carrying the sample flag, their phase value and a saturating sample statistic.

## Interface
- DATA_WIDTH, 32: packet payload width.
- COUNT_WIDTH, 3: phase counter width.
- PERIOD, 8: sampling period. Legal range is 1 ≤ PERIOD ≤ 2^COUNT_WIDTH.
- STAT_WIDTH, 16: sample statistic width.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i__valid  in  1  upstream packet valid.
- i__data  in  DATA_WIDTH  upstream packet payload.
- o__ready  out  1  stage can accept a packet this cycle.
- i__clear  in  1  synchronous restart of phase and statistic.
- o__valid  out  1  output register holds a packet.
- o__data  out  DATA_WIDTH  buffered payload.
- o__sample  out  1  buffered packet was accepted at phase 0.
- o__seq  out  COUNT_WIDTH  phase value at which the buffered packet was accepted.
- i__ready  in  1  downstream accepts the output this cycle.
- o__phase  out  COUNT_WIDTH  current phase counter value.
- o__sample_count  out  STAT_WIDTH  number of sampled packets accepted; saturates.

## Operation
- Ready: o__ready = !o__valid || i__ready, combinational.
- Accept: accept = i__valid && o__ready.
- Effective phase: phase_eff = i__clear ? 0 : phase.
- On accept, the output register loads:
  - o__data ← i__data
  - o__seq ← phase_eff
  - o__sample ← (phase_eff == 0)
  - o__valid ← 1
- Phase update:
  - On accept: phase ← (phase_eff == PERIOD-1) ? 0 : phase_eff + 1.
  - With PERIOD = 1, phase stays 0 and every packet is sampled.
  - On i__clear without accept: phase ← 0.
  - Otherwise phase holds.
- Phase width rule: arithmetic is done in COUNT_WIDTH bits. Because PERIOD ≤ 2^COUNT_WIDTH, there is no overflow beyond the explicit wrap.
- Statistic update:
  - i__clear zeroes the statistic.
  - A sampled accept in the same cycle as i__clear yields 1.
  - Otherwise a sampled accept increments the statistic, saturating at all-ones.
- Drain: when o__valid && i__ready && !accept, o__valid ← 0. Data, sample and seq hold their last values.
- Stall: while o__valid && !i__ready, o__data, o__sample and o__seq are stable, no accept occurs, and the phase does not advance unless i__clear is asserted.
- Drain and refill in the same cycle (o__valid, i__ready and i__valid all high): the register is replaced, o__valid stays 1, and no bubble is inserted.
- Packets are never dropped or duplicated.
- The result of PERIOD = 0 or PERIOD > 2^COUNT_WIDTH is undefined. Simulation raises an elaboration error.

## Timing
- Reset values, applied immediately when reset is low: o__valid 0, o__data 0, o__sample 0, o__seq 0, o__phase 0, o__sample_count 0.
- o__ready = 1 while in reset.
- Reset mid-operation discards any buffered packet.
- The first packet accepted after reset deasserts is sampled.
- Latency: a packet accepted in cycle N appears with o__valid = 1 in cycle N+1.
- Throughput: one packet per cycle while i__ready is held high.
- Combinational paths:
  - The only in-to-out path is i__ready → o__ready.
  - i__valid, i__data and i__clear reach outputs only through registers.
- o__phase and o__sample_count reflect accepts from the previous edge.

## Test plan
- Reset, then data 0..9 back-to-back with i__ready=1:
  - Outputs appear one cycle after each accept.
  - o__seq = 0,1,…,7,0,1.
  - o__sample=1 only for data 0 and 8.
  - o__sample_count=2 and o__phase=2 at the end.
- Backpressure: buffer data 0xAA, hold i__ready=0 for 4 cycles with i__valid=1, data 0xBB.
  - o__ready=0 throughout, o__data stays 0xAA, o__phase unchanged.
  - Raising i__ready gives 0xBB on the following cycle with no bubble.
- Reach phase 5, then assert i__clear together with an accept:
  - The packet leaves with o__seq=0, o__sample=1.
  - o__phase=1, o__sample_count=1.
- STAT_WIDTH=2, PERIOD=1, 6 accepts:
  - Every output has o__sample=1 and o__seq=0.
  - o__sample_count saturates at 3.
- Drop reset low asynchronously (mid-cycle) with o__valid=1 and phase 4:
  - All outputs go to reset values before the next clk edge.
  - After release, the first accepted packet has o__sample=1.
- PERIOD=5, COUNT_WIDTH=3, 11 accepts: o__seq = 0,1,2,3,4,0,1,2,3,4,0 and o__sample_count=3.

Source files
------------

// File: rtl/pkt_sampler_if.sv
// pkt_sampler_if
//   Groups the packet-stream signals of pkt_sampler: the upstream handshake
//   (i__valid/i__data/o__ready), the downstream handshake
//   (o__valid/o__data/o__sample/o__seq/i__ready), and the side controls and
//   status (i__clear, o__phase, o__sample_count).
//   master: the side that drives packets in and takes them out (environment).
//   slave : the sampler itself.
//
// Handshake rule for both sides: a transfer happens on a rising clk edge
// exactly when valid and ready are both high in that cycle; valid must not
// depend on ready, and a valid packet is held stable until it transfers.
interface pkt_sampler_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 3,
    parameter int STAT_WIDTH  = 16
);
    logic                   i__valid;
    logic [DATA_WIDTH-1:0]  i__data;
    logic                   o__ready;
    logic                   i__clear;
    logic                   o__valid;
    logic [DATA_WIDTH-1:0]  o__data;
    logic                   o__sample;
    logic [COUNT_WIDTH-1:0] o__seq;
    logic                   i__ready;
    logic [COUNT_WIDTH-1:0] o__phase;
    logic [STAT_WIDTH-1:0]  o__sample_count;

    modport master (
        output i__valid, i__data, i__clear, i__ready,
        input  o__ready, o__valid, o__data, o__sample, o__seq,
               o__phase, o__sample_count
    );

    modport slave (
        input  i__valid, i__data, i__clear, i__ready,
        output o__ready, o__valid, o__data, o__sample, o__seq,
               o__phase, o__sample_count
    );
endinterface

// File: rtl/pkt_sampler.sv
// pkt_sampler
//   Packet-stream sampling stage. Every accepted packet advances a
//   modulo-PERIOD phase counter; the packet accepted at phase 0 is tagged as
//   a sample. Packets leave through a one-entry registered output carrying
//   the payload, the sample flag, the phase they were accepted at, and a
//   saturating count of sampled packets is kept alongside.
//
// Ports
//   clk    : single clock, rising edge.
//   reset  : asynchronous, active-low reset.
//   bus    : pkt_sampler_if.slave
//            i__valid/i__data/o__ready  upstream handshake
//            o__valid/o__data/o__sample/o__seq/i__ready  downstream handshake
//            i__clear        synchronous restart of phase and statistic
//            o__phase        current phase counter value
//            o__sample_count saturating number of sampled packets accepted
module pkt_sampler #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 3,
    parameter int PERIOD      = 8,
    parameter int STAT_WIDTH  = 16
) (
    input logic          clk,
    input logic          reset,
    pkt_sampler_if.slave bus
);

    if (PERIOD < 1 || PERIOD > (1 << COUNT_WIDTH)) begin : g_bad_period
        $error("pkt_sampler: PERIOD must be in 1..2**COUNT_WIDTH");
    end

    localparam logic [COUNT_WIDTH-1:0] LAST_PHASE = COUNT_WIDTH'(PERIOD - 1);

    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   sample_q;
    logic [COUNT_WIDTH-1:0] seq_q;
    logic [COUNT_WIDTH-1:0] phase_q;
    logic [STAT_WIDTH-1:0]  stat_q;

    logic                   ready;
    logic                   accept;
    logic [COUNT_WIDTH-1:0] phase_eff;
    logic                   sample_eff;
    logic [COUNT_WIDTH-1:0] phase_after;

    // The register can take a new packet when empty or when it is being
    // drained this same cycle, so a full stream flows with no bubbles.
    assign ready       = !valid_q || bus.i__ready;
    assign accept      = bus.i__valid && ready;
    // A clear restarts the phase in the same cycle, so a packet accepted
    // together with i__clear is treated as arriving at phase 0.
    assign phase_eff   = bus.i__clear ? '0 : phase_q;
    assign sample_eff  = (phase_eff == '0);
    // Explicit wrap; with PERIOD == 2**COUNT_WIDTH this coincides with the
    // natural overflow, with PERIOD == 1 the phase stays at 0.
    assign phase_after = (phase_eff == LAST_PHASE) ? '0 : phase_eff + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            sample_q <= 1'b0;
            seq_q    <= '0;
            phase_q  <= '0;
            stat_q   <= '0;
        end else begin
            // Output register: load on accept, otherwise drain if taken.
            if (accept) begin
                valid_q  <= 1'b1;
                data_q   <= bus.i__data;
                sample_q <= sample_eff;
                seq_q    <= phase_eff;
            end else if (valid_q && bus.i__ready) begin
                valid_q  <= 1'b0;
            end

            // Phase counter.
            if (accept) begin
                phase_q <= phase_after;
            end else if (bus.i__clear) begin
                phase_q <= '0;
            end

            // Sample statistic, saturating at all-ones.
            if (bus.i__clear) begin
                stat_q <= (accept && sample_eff) ? STAT_WIDTH'(1) : '0;
            end else if (accept && sample_eff && (stat_q != '1)) begin
                stat_q <= stat_q + 1'b1;
            end
        end
    end

    assign bus.o__ready        = ready;
    assign bus.o__valid        = valid_q;
    assign bus.o__data         = data_q;
    assign bus.o__sample       = sample_q;
    assign bus.o__seq          = seq_q;
    assign bus.o__phase        = phase_q;
    assign bus.o__sample_count = stat_q;

endmodule

// File: tb/tb_pkt_sampler.sv
// tb_pkt_sampler
//   Directed bench for pkt_sampler with three configurations:
//   b0/dut0 defaults (PERIOD 8), b1/dut1 STAT_WIDTH 2 + PERIOD 1,
//   b2/dut2 PERIOD 5. Expected values are hand-computed constants.
module tb_pkt_sampler;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    pkt_sampler_if #(.DATA_WIDTH(32), .COUNT_WIDTH(3), .STAT_WIDTH(16)) b0 ();
    pkt_sampler_if #(.DATA_WIDTH(32), .COUNT_WIDTH(3), .STAT_WIDTH(2))  b1 ();
    pkt_sampler_if #(.DATA_WIDTH(32), .COUNT_WIDTH(3), .STAT_WIDTH(16)) b2 ();

    pkt_sampler #(.DATA_WIDTH(32), .COUNT_WIDTH(3), .PERIOD(8), .STAT_WIDTH(16))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    pkt_sampler #(.DATA_WIDTH(32), .COUNT_WIDTH(3), .PERIOD(1), .STAT_WIDTH(2))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    pkt_sampler #(.DATA_WIDTH(32), .COUNT_WIDTH(3), .PERIOD(5), .STAT_WIDTH(16))
        dut2 (.clk(clk), .reset(reset), .bus(b2));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        b0.i__valid = 1'b0; b0.i__data = '0; b0.i__clear = 1'b0; b0.i__ready = 1'b1;
        b1.i__valid = 1'b0; b1.i__data = '0; b1.i__clear = 1'b0; b1.i__ready = 1'b1;
        b2.i__valid = 1'b0; b2.i__data = '0; b2.i__clear = 1'b0; b2.i__ready = 1'b1;

        // Reset values.
        #2;
        check("rst_valid", b0.o__valid, 0);
        check("rst_data", b0.o__data, 0);
        check("rst_sample", b0.o__sample, 0);
        check("rst_seq", b0.o__seq, 0);
        check("rst_phase", b0.o__phase, 0);
        check("rst_count", b0.o__sample_count, 0);
        check("rst_ready", b0.o__ready, 1);
        #10 reset = 1'b1;

        // Back-to-back stream 0..9.
        for (int k = 0; k < 10; k++) begin
            b0.i__valid = 1'b1;
            b0.i__data  = k;
            tick();
            check("s_valid", b0.o__valid, 1);
            check("s_data", b0.o__data, k);
            check("s_seq", b0.o__seq, k % 8);
            check("s_sample", b0.o__sample, (k % 8) == 0);
        end
        check("s_count", b0.o__sample_count, 2);
        check("s_phase", b0.o__phase, 2);

        // Backpressure: AA buffered, BB waits.
        b0.i__data = 32'hAA;
        tick();
        check("bp_aa", b0.o__data, 32'hAA);
        b0.i__ready = 1'b0;
        b0.i__data  = 32'hBB;
        #1;
        check("bp_ready0", b0.o__ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_ready", b0.o__ready, 0);
            check("bp_hold", b0.o__data, 32'hAA);
            check("bp_valid", b0.o__valid, 1);
            check("bp_phase", b0.o__phase, 3);
        end
        b0.i__ready = 1'b1;
        #1;
        check("bp_ready1", b0.o__ready, 1);
        tick();
        check("bp_bb", b0.o__data, 32'hBB);
        check("bp_bb_valid", b0.o__valid, 1);
        check("bp_bb_seq", b0.o__seq, 3);

        // Reach phase 5, then clear together with an accept.
        b0.i__data = 32'h44;
        tick();
        check("cl_phase5", b0.o__phase, 5);
        b0.i__data  = 32'h55;
        b0.i__clear = 1'b1;
        tick();
        b0.i__clear = 1'b0;
        check("cl_data", b0.o__data, 32'h55);
        check("cl_seq", b0.o__seq, 0);
        check("cl_sample", b0.o__sample, 1);
        check("cl_phase", b0.o__phase, 1);
        check("cl_count", b0.o__sample_count, 1);

        // Drive to phase 4 with a packet buffered, then async reset.
        for (int k = 0; k < 3; k++) begin
            b0.i__data = 32'h60 + k;
            tick();
        end
        b0.i__valid = 1'b0;
        check("ar_pre_phase", b0.o__phase, 4);
        check("ar_pre_valid", b0.o__valid, 1);
        b0.i__ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("ar_valid", b0.o__valid, 0);
        check("ar_data", b0.o__data, 0);
        check("ar_seq", b0.o__seq, 0);
        check("ar_phase", b0.o__phase, 0);
        check("ar_count", b0.o__sample_count, 0);
        check("ar_ready", b0.o__ready, 1);
        #2 reset = 1'b1;
        b0.i__ready = 1'b1;
        b0.i__valid = 1'b1;
        b0.i__data  = 32'h77;
        tick();
        b0.i__valid = 1'b0;
        check("ar_first_data", b0.o__data, 32'h77);
        check("ar_first_sample", b0.o__sample, 1);
        check("ar_first_seq", b0.o__seq, 0);

        // PERIOD 1, STAT_WIDTH 2: all sampled, count saturates at 3.
        for (int k = 0; k < 6; k++) begin
            b1.i__valid = 1'b1;
            b1.i__data  = 32'h100 + k;
            tick();
            check("p1_data", b1.o__data, 32'h100 + k);
            check("p1_sample", b1.o__sample, 1);
            check("p1_seq", b1.o__seq, 0);
            check("p1_count", b1.o__sample_count, (k < 3) ? k + 1 : 3);
        end
        b1.i__valid = 1'b0;

        // PERIOD 5: seq 0..4 repeating, three samples in 11 accepts.
        for (int k = 0; k < 11; k++) begin
            b2.i__valid = 1'b1;
            b2.i__data  = 32'h200 + k;
            tick();
            check("p5_seq", b2.o__seq, k % 5);
            check("p5_sample", b2.o__sample, (k % 5) == 0);
        end
        b2.i__valid = 1'b0;
        check("p5_count", b2.o__sample_count, 3);
        check("p5_phase", b2.o__phase, 1);
        tick();
        check("p5_drain", b2.o__valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
